// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared types and constants for the UART transmit engine.
package uart_tx_pkg;

  // Frame FSM states, Gray-style so each regular step flips one bit.
  typedef enum logic [2:0] {
    S_IDLE   = 3'b000,
    S_START  = 3'b001,
    S_DATA   = 3'b011,
    S_PARITY = 3'b010,
    S_STOP1  = 3'b110,
    S_STOP2  = 3'b111
`ifdef UART_TX_BREAK_EN
    ,
    S_BREAK  = 3'b101
`endif
  } tx_state_e;

  // Parity type encodings as seen on PAR_TYP.
  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;

  // Level of the serial line when nothing is being sent.
  localparam logic LINE_IDLE = 1'b1;

  // Per-frame configuration captured together with the payload.
  typedef struct packed {
    logic par_en;
    logic par_typ;
    logic stop2;
  } frame_cfg_t;

endpackage

// File: rtl/uart_tx_shifter.sv
// uart_tx_shifter: payload shift register, data-bit counter and parity of
// the captured payload. Tells the FSM when the last data bit is on the line.
module uart_tx_shifter
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  bit_cur,
  output logic                  bit_next,
  output logic                  done,
  output logic                  data_parity
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  logic [DATA_WIDTH-1:0] shift_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  par_q;

  // Capture a new payload or move one bit toward the line per data bit-time.
  always_ff @(posedge CLK) begin
    // NOTE: non-blocking so every register updates from its pre-edge value.
    if (RST) begin
      shift_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
    end else if (load) begin
      shift_q <= load_data;
      cnt_q   <= '0;
      par_q   <= ^load_data;
    end else if (shift) begin
      shift_q <= {1'b0, shift_q[DATA_WIDTH-1:1]};
      cnt_q   <= cnt_q + CNT_W'(1);
    end
  end

  assign bit_cur     = shift_q[0];
  assign bit_next    = shift_q[1];
  assign done        = (cnt_q == CNT_W'(DATA_WIDTH - 1));
  assign data_parity = par_q;

endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit engine. Frame FSM and registered line/handshake
// outputs; the payload datapath lives in uart_tx_shifter.
// Optional feature: define UART_TX_BREAK_EN to add Break_Req and a BREAK_LEN
// bit-time break condition.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BREAK_LEN  = 13
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Tick,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
`ifdef UART_TX_BREAK_EN
  input  logic                  Break_Req,
`endif
  output logic                  Data_Ack,
  output logic                  TX_OUT,
  output logic                  Busy
);

  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
    $error("uart_tx_ctrl: DATA_WIDTH must be 5..9");
  end
  if (BREAK_LEN < 2 || BREAK_LEN > 255) begin : g_bad_break
    $error("uart_tx_ctrl: BREAK_LEN must be 2..255");
  end

  tx_state_e  state_q;
  frame_cfg_t cfg_q;

  logic sh_bit_cur, sh_bit_next, sh_done, sh_parity;
  logic at_decision, brk_go, load;

`ifdef UART_TX_BREAK_EN
  logic [7:0] brk_cnt_q;
  logic       brk_stop_q;  // current STOP1 closes a break, not a frame
  assign brk_go = Break_Req;
`else
  assign brk_go = 1'b0;
`endif

  // Idle, or the final stop bit of a frame: the points where a new request is taken.
  assign at_decision = (state_q == S_IDLE) || (state_q == S_STOP2) ||
                       ((state_q == S_STOP1) && !cfg_q.stop2
`ifdef UART_TX_BREAK_EN
                        && !brk_stop_q
`endif
                       );
  assign load = Tick && at_decision && Data_Valid && !brk_go;

  uart_tx_shifter #(.DATA_WIDTH(DATA_WIDTH)) u_shifter (
    .CLK         (CLK),
    .RST         (RST),
    .load        (load),
    .shift       (Tick && (state_q == S_DATA)),
    .load_data   (P_DATA),
    .bit_cur     (sh_bit_cur),
    .bit_next    (sh_bit_next),
    .done        (sh_done),
    .data_parity (sh_parity)
  );

  // Frame sequencing with registered line, busy and acknowledge outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      cfg_q    <= '{par_en: 1'b0, par_typ: PAR_EVEN, stop2: 1'b0};
      TX_OUT   <= LINE_IDLE;
      Busy     <= 1'b0;
      Data_Ack <= 1'b0;
`ifdef UART_TX_BREAK_EN
      brk_cnt_q  <= '0;
      brk_stop_q <= 1'b0;
`endif
    end else begin
      Data_Ack <= 1'b0;
      if (Tick) begin
        if (at_decision) begin
`ifdef UART_TX_BREAK_EN
          if (Break_Req) begin
            state_q   <= S_BREAK;
            brk_cnt_q <= '0;
            TX_OUT    <= ~LINE_IDLE;
            Busy      <= 1'b1;
          end else
`endif
          if (Data_Valid) begin
            state_q  <= S_START;
            cfg_q    <= '{par_en: PAR_EN, par_typ: PAR_TYP, stop2: STOP2};
            Data_Ack <= 1'b1;
            TX_OUT   <= ~LINE_IDLE;
            Busy     <= 1'b1;
          end else begin
            state_q <= S_IDLE;
            TX_OUT  <= LINE_IDLE;
            Busy    <= 1'b0;
          end
        end else begin
          case (state_q)
            S_START: begin
              state_q <= S_DATA;
              TX_OUT  <= sh_bit_cur;
            end
            S_DATA: begin
              if (!sh_done) begin
                TX_OUT <= sh_bit_next;
              end else if (cfg_q.par_en) begin
                state_q <= S_PARITY;
                TX_OUT  <= sh_parity ^ (cfg_q.par_typ == PAR_ODD);
              end else begin
                state_q <= S_STOP1;
                TX_OUT  <= LINE_IDLE;
              end
            end
            S_PARITY: begin
              state_q <= S_STOP1;
              TX_OUT  <= LINE_IDLE;
            end
            S_STOP1: begin
`ifdef UART_TX_BREAK_EN
              if (brk_stop_q) begin
                state_q    <= S_IDLE;
                brk_stop_q <= 1'b0;
                Busy       <= 1'b0;
              end else
`endif
              begin
                state_q <= S_STOP2;
              end
              TX_OUT <= LINE_IDLE;
            end
`ifdef UART_TX_BREAK_EN
            S_BREAK: begin
              if (brk_cnt_q == 8'(BREAK_LEN - 1)) begin
                state_q    <= S_STOP1;
                brk_stop_q <= 1'b1;
                TX_OUT     <= LINE_IDLE;
              end else begin
                brk_cnt_q <= brk_cnt_q + 8'd1;
              end
            end
`endif
            default: begin
              state_q <= S_IDLE;
              TX_OUT  <= LINE_IDLE;
              Busy    <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Parametrised UART transmit engine. It integrates the frame FSM, shift register, bit counter and parity generator into one block. It supports configurable data width, even/odd/no parity, 1 or 2 stop bits, and back-to-back frames with no idle gap. It sits between the TX-side data source (valid/ack handshake) and the TX pin, and is paced by an external baud-rate enable (Tick) from the clock divider.

Parameters:
DATA_WIDTH, 8, payload bits per frame (5..9).
BREAK_LEN, 13, break duration in bit-times; used only when UART_TX_BREAK_EN is defined (2..255).

Ports:
CLK  in  1  system clock.
RST  in  1  synchronous, active-high reset.
Tick  in  1  one-CLK-wide baud enable; one bit-time = one Tick period.
P_DATA  in  DATA_WIDTH  parallel payload, transmitted LSB first.
Data_Valid  in  1  payload request; held high until Data_Ack.
PAR_EN  in  1  parity bit enable.
PAR_TYP  in  1  parity type: 0 = even, 1 = odd.
STOP2  in  1  1 = two stop bits, 0 = one stop bit.
Data_Ack  out  1  one-cycle pulse; P_DATA and the config inputs were captured.
TX_OUT  out  1  registered serial line, idles high.
Busy  out  1  high while a frame or break is on the line.

Behaviour:
- Reset is synchronous and active-high; it has priority over all other logic. Reset values: state=IDLE, TX_OUT=1, Busy=0, Data_Ack=0, shift register=0, bit counter=0.
- Reset asserted mid-frame aborts the frame. TX_OUT returns to 1 on the next edge. There is no partial-stop completion.
- All state advances occur only on cycles where Tick=1. TX_OUT, Busy and Data_Ack are all registered.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2 (plus BREAK when the feature is compiled in).
- IDLE: TX_OUT=1. On Tick & Data_Valid:
  - latch P_DATA into the shifter, and PAR_EN, PAR_TYP, STOP2 into frame-config registers;
  - pulse Data_Ack;
  - go to START.
  - Mid-frame changes to the config inputs are ignored.
- START: TX_OUT=0 for one bit-time; bit counter cleared; on Tick go to DATA.
- DATA: TX_OUT=shifter[0]. On each Tick, shift right and increment the counter. After the DATA_WIDTH-th bit-time:
  - go to PARITY if latched PAR_EN=1,
  - otherwise go to STOP1.
- PARITY: TX_OUT = XOR-reduce(latched data) XOR latched PAR_TYP. One bit-time, then STOP1.
- STOP1: TX_OUT=1. On Tick go to STOP2 if latched STOP2=1; otherwise the frame ends.
- STOP2: TX_OUT=1; frame ends on Tick.
- Frame end:
  - if Data_Valid=1 on the same Tick, accept the next payload (Data_Ack pulse) and go directly to START, with no idle bit;
  - otherwise go to IDLE.
- Busy = 1 from the cycle TX_OUT first goes low until the cycle the FSM re-enters IDLE; it stays high across back-to-back frames.
- Frame length in bit-times = 1 + DATA_WIDTH + PAR_EN + 1 + STOP2.
- Data_Valid without Tick has no effect. Tick while in IDLE with Data_Valid=0 has no effect.
- Bit counter width = $clog2(DATA_WIDTH+1). Parity is computed over DATA_WIDTH bits only.

Optional Feature:
Macro UART_TX_BREAK_EN.
- Defined:
  - adds input Break_Req (1 bit) and state BREAK;
  - in IDLE or at frame end on Tick, Break_Req has priority over Data_Valid (no Data_Ack);
  - BREAK drives TX_OUT=0 for BREAK_LEN bit-times, with Busy=1, then holds STOP1 for one bit-time and returns to IDLE;
  - Break_Req is sampled only at those decision points.
- Not defined: no port, no state; the BREAK_LEN parameter is ignored.

Decomposition:
- Package uart_tx_pkg holds:
  - the state enum (3-bit, Gray-style encoding);
  - PAR_EVEN/PAR_ODD constants;
  - the idle-line constant.
- One sub-module, uart_tx_shifter: load/shift register plus bit counter plus parity XOR, with a done flag to the FSM. The FSM and output muxing stay in the top.

Test Plan:
- DATA_WIDTH=8, Tick every 4 CLK, P_DATA=8'hA5, PAR_EN=0, STOP2=0 -> TX_OUT bit sequence 0,1,0,1,0,0,1,0,1,1; each bit lasts 4 CLK; one Data_Ack pulse; Busy high for 40 CLK.
- P_DATA=8'hA5, PAR_EN=1: PAR_TYP=0 -> parity bit 0; PAR_TYP=1 -> parity bit 1. Frame is 11 bit-times.
- STOP2=1, PAR_EN=1, P_DATA=8'h01 -> 12 bit-times with two high stop bits; toggling STOP2 mid-frame has no effect.
- Data_Valid held high with P_DATA=8'h00 then 8'hFF -> second start bit directly follows the first stop bit; Busy never drops; two Data_Ack pulses.
- RST asserted during DATA bit 3 -> next cycle TX_OUT=1, Busy=0, Data_Ack=0, state IDLE; next frame transmits correctly.
- With UART_TX_BREAK_EN and BREAK_LEN=13: Break_Req and Data_Valid both high in IDLE -> 13 bit-times low, then 1 high, no Data_Ack; the pending frame starts afterwards.
